// File: rtl/operand_fetch.sv
// operand_fetch: issue stage with pending-write scoreboard, bank read/write ports; OPERAND_BYPASS_EN adds same-cycle wb bypass.
// Latency: 1 cycle from accept (in_valid && in_ready) to out_valid.
// Backpressure: in_ready drops on RAW/WAW hazard, on flush, or while a held bundle sees out_ready low.
module operand_fetch #(
  parameter int XLEN            = 32,
  parameter bit SB_CLR_ON_FLUSH = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [4:0]      in_rd,
  input  logic            in_rd_we,
  input  logic [XLEN-1:0] in_imm,
  output logic [4:0]      rf_sel_a,
  output logic [4:0]      rf_sel_b,
  input  logic [XLEN-1:0] rf_data_a,
  input  logic [XLEN-1:0] rf_data_b,
  output logic [XLEN-1:0] rf_data_in,
  output logic [4:0]      rf_sel_in,
  output logic            rf_load_en,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_op_a,
  output logic [XLEN-1:0] out_op_b,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic [XLEN-1:0] out_imm
);

  logic [31:0]     pend;
  logic [31:0]     pend_nxt;
  logic            hz_a;
  logic            hz_b;
  logic            hz_waw;
  logic            hazard;
  logic            fire;
  logic [XLEN-1:0] op_a_nxt;
  logic [XLEN-1:0] op_b_nxt;

  assign rf_sel_a   = in_rs1;
  assign rf_sel_b   = in_rs2;
  assign rf_data_in = wb_data;
  assign rf_sel_in  = wb_rd;
  assign rf_load_en = wb_valid && (wb_rd != 5'd0);

`ifdef OPERAND_BYPASS_EN
  logic wb_hit_a;
  logic wb_hit_b;
  logic wb_hit_d;

  // A writeback landing this cycle resolves the hazard and supplies the operand directly.
  assign wb_hit_a = wb_valid && (wb_rd == in_rs1) && (in_rs1 != 5'd0);
  assign wb_hit_b = wb_valid && (wb_rd == in_rs2) && (in_rs2 != 5'd0);
  assign wb_hit_d = wb_valid && (wb_rd == in_rd);

  assign hz_a   = (in_rs1 != 5'd0) && pend[in_rs1] && !wb_hit_a;
  assign hz_b   = (in_rs2 != 5'd0) && pend[in_rs2] && !wb_hit_b;
  assign hz_waw = in_rd_we && (in_rd != 5'd0) && pend[in_rd] && !wb_hit_d;

  assign op_a_nxt = (in_rs1 == 5'd0) ? '0 : (wb_hit_a ? wb_data : rf_data_a);
  assign op_b_nxt = (in_rs2 == 5'd0) ? '0 : (wb_hit_b ? wb_data : rf_data_b);
`else
  // Without bypass the consumer waits until the bank itself holds the written value.
  assign hz_a   = (in_rs1 != 5'd0) && pend[in_rs1];
  assign hz_b   = (in_rs2 != 5'd0) && pend[in_rs2];
  assign hz_waw = in_rd_we && (in_rd != 5'd0) && pend[in_rd];

  assign op_a_nxt = (in_rs1 == 5'd0) ? '0 : rf_data_a;
  assign op_b_nxt = (in_rs2 == 5'd0) ? '0 : rf_data_b;
`endif

  assign hazard   = hz_a || hz_b || hz_waw;
  assign in_ready = !hazard && (!out_valid || out_ready) && !flush;
  assign fire     = in_valid && in_ready;

  // Clears first so that an issue to the same index in the same cycle stays pending.
  always_comb begin
    pend_nxt = pend;
    if (wb_valid) begin
      pend_nxt[wb_rd] = 1'b0;
    end
    if (SB_CLR_ON_FLUSH && flush && out_valid && out_rd_we) begin
      pend_nxt[out_rd] = 1'b0;
    end
    if (fire && in_rd_we) begin
      pend_nxt[in_rd] = 1'b1;
    end
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend <= '0;
    end else begin
      pend <= pend_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_op_a  <= '0;
      out_op_b  <= '0;
      out_rd    <= 5'd0;
      out_rd_we <= 1'b0;
      out_imm   <= '0;
    end else if (fire) begin
      out_valid <= 1'b1;
      out_op_a  <= op_a_nxt;
      out_op_b  <= op_b_nxt;
      out_rd    <= in_rd;
      out_rd_we <= in_rd_we;
      out_imm   <= in_imm;
    end else if (flush || out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
